greater_than_sweep: RTL and testbench
=====================================

# greater_than_sweep

Self-test sequencer that sits around the 2-bit `greater_than` comparator. It feeds the comparator with all 16 `{A,B}` combinations and consumes its `F` output, one bit per vector. It packs the sampled `F` values into a 16-bit result word and checks them against the fixed golden map for A > B. It is the on-chip replacement for the exhaustive stimulus loop that currently exists only in simulation.

## Interface
- `SETTLE`, default 2: cycles each vector is held before `F` is sampled; legal range 1..15.

Ports (clock and reset first):
- `clk` — in — 1: single clock; all state updates on the rising edge.
- `rst` — in — 1: reset, synchronous and active-high.
- `start` — in — 1: request a sweep; honoured only in IDLE.
- `f_in` — in — 1: comparator output `F`.
- `a_out` — out — 2: drives comparator input `A`.
- `b_out` — out — 2: drives comparator input `B`.
- `busy` — out — 1: high while the sweep is running.
- `done` — out — 1: one-cycle pulse at sweep end.
- `result` — out — 16: bit i = `f_in` sampled for vector i, where i = `{A,B}`.
- `pass` — out — 1: `result == 16'h7310`; valid from `done` onward.
- `fail_count` — out — 5: number of vectors whose sampled bit differs from golden (0..16).

## Operation
- Golden bit i = (i[3:2] > i[1:0]). Set bits are 4, 8, 9, 12, 13, 14, giving `16'h7310`.
- `{a_out,b_out}` always equals the internal 4-bit vector index `idx`.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `busy`=0, `idx`=0. If `start`=1 at an edge:
    - go to RUN;
    - clear `result`, `fail_count`, settle counter `cnt`;
    - `idx`=0.
  - RUN: `busy`=1, `start` ignored. At each edge:
    - if `cnt`==SETTLE-1, sample: `result[idx]` <= `f_in`; `fail_count` increments if `f_in` != golden[idx]. Then:
      - if `idx`==15, go to DONE and set `idx` <= 0;
      - else `idx`++ and `cnt` <= 0.
    - else `cnt`++.
  - DONE: `busy`=0 and `done`=1 for exactly one cycle, then IDLE unconditionally. A `start` seen during DONE is ignored.
- `result`, `fail_count` and `pass` hold their values after DONE until the next accepted `start`.
- `fail_count` saturation is not needed (maximum 16 fits in 5 bits).
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `result`=0, `fail_count`=0, state IDLE.
  - `pass` is combinational from `result`, so it reads 0 after reset.
- Reset mid-sweep: all registers return to reset values on that edge, and no `done` pulse is produced.
- `rst` has priority over `start` in the same cycle.

## Timing
- `start` is sampled at edge E0. `busy` rises after E0, and vector 0 is driven in the same cycle.
- Each vector is driven for exactly SETTLE cycles. `f_in` is sampled at the edge ending the last of those cycles.
  - The comparator path must settle within SETTLE cycles minus setup.
- `busy` stays high for exactly 16×SETTLE cycles. `done` is high in the following cycle. Total from `start` edge to the `done` cycle is 16×SETTLE+1 cycles.
- The final `result` and `fail_count` are visible in the same cycle `done` is high.
- Back-to-back sweeps: the earliest accepted `start` is at the edge ending the DONE cycle's successor (first IDLE cycle).

## Test plan
- Correct comparator model, SETTLE=2, pulse `start`:
  - `busy` high 32 cycles, then `done` for 1 cycle;
  - `result`=16'h7310, `pass`=1, `fail_count`=0;
  - `{a_out,b_out}` steps 0..15, two cycles each.
- `f_in` tied to 0 → `result`=16'h0000, `fail_count`=6, `pass`=0.
- Faulty model computing A>=B → `result`=16'hF731, `fail_count`=4, `pass`=0.
- `start` re-asserted during RUN and during DONE → sweep length unchanged, exactly one `done` pulse per accepted `start`.
- `rst` asserted at vector 7 of a sweep → next cycle all outputs at reset values. No `done` pulse follows, and a fresh `start` gives a full correct sweep.
- SETTLE=1 → `busy` exactly 16 cycles, `result`=16'h7310, `done` at cycle 17 after `start` edge.

Source files
------------

// File: rtl/greater_than_sweep.sv
// Exhaustive self-test of the 2-bit A>B comparator: drives all 16 {A,B} vectors, packs F into result.
// Latency: 16*SETTLE busy cycles plus one done cycle per sweep; start is ignored unless idle.
module greater_than_sweep #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic [1:0]  a_out,
    output logic [1:0]  b_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        pass,
    output logic [4:0]  fail_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit i is set when i[3:2] > i[1:0].
    localparam logic [15:0] GOLDEN      = 16'h7310;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0]  IDX_LAST    = 4'd15;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  idx_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [15:0] result_nxt;
    logic [4:0]  fail_count_nxt;
    logic        sample_now;
    logic        bit_bad;

    assign sample_now = (cnt == SETTLE_LAST);
    assign bit_bad    = (f_in != GOLDEN[idx]);

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        cnt_nxt        = cnt;
        result_nxt     = result;
        fail_count_nxt = fail_count;
        case (state)
            IDLE: begin
                idx_nxt = 4'd0;
                if (start) begin
                    state_nxt      = RUN;
                    cnt_nxt        = 4'd0;
                    result_nxt     = 16'h0000;
                    fail_count_nxt = 5'd0;
                end
            end
            RUN: begin
                if (sample_now) begin
                    result_nxt[idx] = f_in;
                    fail_count_nxt  = fail_count + 5'(bit_bad);
                    cnt_nxt         = 4'd0;
                    if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                        idx_nxt   = 4'd0;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                // Single-cycle pulse; a start seen here is deliberately dropped.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            cnt        <= 4'd0;
            result     <= 16'h0000;
            fail_count <= 5'd0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            result     <= result_nxt;
            fail_count <= fail_count_nxt;
        end
    end

    assign a_out = idx[3:2];
    assign b_out = idx[1:0];
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign pass  = (result == GOLDEN);

endmodule

// File: tb/tb_greater_than_sweep.sv
// Bench for greater_than_sweep: SETTLE=2 and SETTLE=1 instances, behavioural comparator and reference map.
module tb_greater_than_sweep;

    logic        clk = 1'b0;
    logic        rst0, start0, f0, rst1, start1, f1;
    logic [1:0]  a0, b0, a1, b1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] res0, res1;
    logic [4:0]  fc0, fc1;
    logic [15:0] tab0 = 16'h0000;
    logic [15:0] tab1 = 16'h0000;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Comparator stand-ins: F is a table lookup on the driven {A,B}.
    assign f0 = tab0[{a0, b0}];
    assign f1 = tab1[{a1, b1}];

    greater_than_sweep #(.SETTLE(2)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .f_in(f0), .a_out(a0), .b_out(b0),
        .busy(busy0), .done(done0), .result(res0), .pass(pass0), .fail_count(fc0)
    );

    greater_than_sweep #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .f_in(f1), .a_out(a1), .b_out(b1),
        .busy(busy1), .done(done1), .result(res1), .pass(pass1), .fail_count(fc1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind 0: A>B, 1: stuck at 0, 2: A>=B
    function automatic logic [15:0] ref_map(input int kind);
        logic [15:0] m;
        m = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            int a = i / 4;
            int b = i % 4;
            case (kind)
                0: m[i] = (a > b);
                2: m[i] = (a >= b);
                default: m[i] = 1'b0;
            endcase
        end
        return m;
    endfunction

    function automatic int n_diff(input logic [15:0] m);
        logic [15:0] g;
        int n;
        g = ref_map(0);
        n = 0;
        for (int i = 0; i < 16; i++) if (m[i] != g[i]) n++;
        return n;
    endfunction

    function automatic logic [3:0] obs_vec(input int sel);
        return sel != 0 ? {a1, b1} : {a0, b0};
    endfunction
    function automatic logic obs_busy(input int sel);
        return sel != 0 ? busy1 : busy0;
    endfunction
    function automatic logic obs_done(input int sel);
        return sel != 0 ? done1 : done0;
    endfunction
    function automatic logic [15:0] obs_res(input int sel);
        return sel != 0 ? res1 : res0;
    endfunction
    function automatic logic [4:0] obs_fc(input int sel);
        return sel != 0 ? fc1 : fc0;
    endfunction
    function automatic logic obs_pass(input int sel);
        return sel != 0 ? pass1 : pass0;
    endfunction

    task automatic drive_start(input int sel, input logic v);
        if (sel != 0) start1 = v; else start0 = v;
    endtask

    task automatic sweep(input int sel, input logic [15:0] tab, input bit poke,
                         input logic [15:0] exp_res, input logic [4:0] exp_fc, input string tag);
        int          s;
        int          cyc;
        int          busy_n;
        bit          seen_done;
        logic [3:0]  v;
        s = (sel != 0) ? 1 : 2;
        if (sel != 0) tab1 = tab; else tab0 = tab;
        @(negedge clk);
        drive_start(sel, 1'b1);
        @(negedge clk);
        drive_start(sel, 1'b0);
        cyc = 1;
        busy_n = 0;
        seen_done = 0;
        while (!seen_done && cyc <= 16 * s + 8) begin
            if (obs_busy(sel)) begin
                busy_n++;
                v = 4'((cyc - 1) / s);
                check({tag, "_vec"}, 32'(obs_vec(sel)), 32'(v));
            end
            if (obs_done(sel)) begin
                seen_done = 1;
            end else begin
                if (poke) drive_start(sel, 1'($urandom_range(0, 1)));
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_done_cycle"}, seen_done ? cyc : 0, 16 * s + 1);
        check({tag, "_busy_len"}, busy_n, 16 * s);
        check({tag, "_result"}, 32'(obs_res(sel)), 32'(exp_res));
        check({tag, "_fail_count"}, 32'(obs_fc(sel)), 32'(exp_fc));
        check({tag, "_pass"}, 32'(obs_pass(sel)), 32'(exp_res == ref_map(0)));
        drive_start(sel, poke);
        @(negedge clk);
        drive_start(sel, 1'b0);
        check({tag, "_done_width"}, 32'(obs_done(sel)), 0);
        check({tag, "_idle_busy"}, 32'(obs_busy(sel)), 0);
        @(negedge clk);
        check({tag, "_no_restart"}, 32'(obs_busy(sel)), 0);
        check({tag, "_hold_result"}, 32'(obs_res(sel)), 32'(exp_res));
        check({tag, "_hold_fc"}, 32'(obs_fc(sel)), 32'(exp_fc));
    endtask

    task automatic reset_mid_sweep();
        int  k;
        int  dones;
        tab0 = ref_map(0);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while (obs_vec(0) != 4'd7 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rst_reach_vec7", 32'(obs_vec(0)), 7);
        rst0 = 1'b1;
        @(negedge clk);
        check("rst_a", 32'(a0), 0);
        check("rst_b", 32'(b0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_result", 32'(res0), 0);
        check("rst_fc", 32'(fc0), 0);
        check("rst_pass", 32'(pass0), 0);
        rst0 = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done0 || busy0) dones++;
        end
        check("rst_no_done", dones, 0);
    endtask

    initial begin
        logic [15:0] t;
        int          sel;
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vec0", 32'({a0, b0}), 0);
        check("reset_busy0", 32'(busy0), 0);
        check("reset_done0", 32'(done0), 0);
        check("reset_result0", 32'(res0), 0);
        check("reset_fc0", 32'(fc0), 0);
        check("reset_pass0", 32'(pass0), 0);
        check("reset_vec1", 32'({a1, b1}), 0);
        check("reset_busy1", 32'(busy1), 0);
        check("reset_result1", 32'(res1), 0);
        rst0 = 1'b0; rst1 = 1'b0;

        sweep(0, ref_map(0), 1'b0, 16'h7310, 5'd0, "gt");
        sweep(0, ref_map(1), 1'b0, 16'h0000, 5'd6, "zero");
        sweep(0, ref_map(2), 1'b0, 16'hF731, 5'd4, "ge");
        sweep(0, ref_map(0), 1'b1, 16'h7310, 5'd0, "poke");
        reset_mid_sweep();
        sweep(0, ref_map(0), 1'b0, 16'h7310, 5'd0, "after_rst");
        sweep(1, ref_map(0), 1'b0, 16'h7310, 5'd0, "s1");
        sweep(1, ref_map(2), 1'b1, 16'hF731, 5'd4, "s1_ge");

        for (int r = 0; r < 8; r++) begin
            t = 16'($urandom);
            sel = int'($urandom_range(0, 1));
            sweep(sel, t, 1'($urandom_range(0, 1)), t, 5'(n_diff(t)), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
